// File: rtl/traffic_sink.sv
// traffic_sink: NoC receive endpoint. Accepts flits over valid/ready, reassembles
// head/body/tail packets, checks destination and framing, and keeps saturating
// packet/flit/error/latency statistics. Optional LFSR backpressure.
module traffic_sink #(
   parameter int unsigned DATA_BITS = 32,
   parameter int unsigned ADDR_BITS = 4,
   parameter int unsigned MY_ADDR   = 0,
   parameter int unsigned TS_BITS   = 16,
   parameter int unsigned CNT_BITS  = 16,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   input  logic [1:0]           in_type,
   input  logic [DATA_BITS-1:0] in_data,
   output logic                 in_ready,
   input  logic                 stall_en,
   output logic                 busy,
   output logic [CNT_BITS-1:0]  rx_packets,
   output logic [CNT_BITS-1:0]  rx_flits,
   output logic [CNT_BITS-1:0]  err_count,
   output logic [31:0]          lat_sum,
   output logic [TS_BITS-1:0]   lat_max
);

   typedef enum logic [0:0] {StIdle, StBody} state_t;

   localparam logic [1:0] TypeBody   = 2'b00;
   localparam logic [1:0] TypeTail   = 2'b01;
   localparam logic [1:0] TypeHead   = 2'b10;
   localparam logic [1:0] TypeSingle = 2'b11;

   localparam logic [ADDR_BITS-1:0] MyAddr = ADDR_BITS'(MY_ADDR);

   state_t               state_q, state_d;
   logic [TS_BITS-1:0]   ts_q, ts_d;
   logic                 bad_q, bad_d;
   logic [TS_BITS-1:0]   now_q;
   logic [15:0]          lfsr_q, lfsr_d;
   logic [CNT_BITS-1:0]  pkt_q, pkt_d;
   logic [CNT_BITS-1:0]  flit_q, flit_d;
   logic [CNT_BITS-1:0]  err_q, err_d;
   logic [31:0]          lsum_q, lsum_d;
   logic [TS_BITS-1:0]   lmax_q, lmax_d;

   logic                 accept;
   logic [ADDR_BITS-1:0] dest;
   logic [TS_BITS-1:0]   ts_in;
   logic                 dest_ok;
   logic                 good;
   logic [1:0]           err_inc;
   logic [TS_BITS-1:0]   lat_ts;
   logic [TS_BITS-1:0]   latency;
   logic                 unused_data;

   assign dest        = in_data[ADDR_BITS-1:0];
   assign ts_in       = in_data[ADDR_BITS+TS_BITS-1:ADDR_BITS];
   assign dest_ok     = (dest == MyAddr);
   assign unused_data = ^in_data;

   // Ready depends only on the LFSR register and the stall mode; forced low in reset.
   assign in_ready = reset & (~stall_en | (lfsr_q[1:0] != 2'b00));
   assign accept   = in_valid & in_ready;

   // Fibonacci LFSR, taps 16,14,13,11 (shift-right form).
   assign lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

   // Packet FSM: decode the accepted flit into state change, good-packet and error events.
   always_comb begin
      state_d = state_q;
      ts_d    = ts_q;
      bad_d   = bad_q;
      good    = 1'b0;
      err_inc = 2'd0;
      lat_ts  = ts_in;
      if (accept) begin
         unique case (state_q)
            StIdle: begin
               case (in_type)
                  TypeSingle: begin
                     if (dest_ok) good = 1'b1;
                     else         err_inc = 2'd1;
                  end
                  TypeHead: begin
                     ts_d    = ts_in;
                     bad_d   = ~dest_ok;
                     state_d = StBody;
                  end
                  default: err_inc = 2'd1;
               endcase
            end
            StBody: begin
               case (in_type)
                  TypeBody: ;
                  TypeTail: begin
                     if (bad_q) err_inc = 2'd1;
                     else       good = 1'b1;
                     lat_ts  = ts_q;
                     state_d = StIdle;
                  end
                  TypeHead: begin
                     // Abort the open packet and start a new one.
                     err_inc = 2'd1;
                     ts_d    = ts_in;
                     bad_d   = ~dest_ok;
                  end
                  default: begin
                     // Aborting single: abort error plus its own address error if any.
                     err_inc = dest_ok ? 2'd1 : 2'd2;
                     good    = dest_ok;
                     state_d = StIdle;
                  end
               endcase
            end
            default: state_d = StIdle;
         endcase
      end
   end

   assign latency = now_q - lat_ts;

   // Saturating statistics next-state.
   always_comb begin
      logic [CNT_BITS:0] pkt_sum;
      logic [CNT_BITS:0] flit_sum;
      logic [CNT_BITS:0] err_sum;
      logic [32:0]       lsum_sum;
      pkt_sum  = {1'b0, pkt_q} + (CNT_BITS+1)'(good);
      flit_sum = {1'b0, flit_q} + (CNT_BITS+1)'(accept);
      err_sum  = {1'b0, err_q} + (CNT_BITS+1)'(err_inc);
      lsum_sum = {1'b0, lsum_q} + (good ? 33'(latency) : 33'd0);
      pkt_d    = pkt_sum[CNT_BITS]  ? '1 : pkt_sum[CNT_BITS-1:0];
      flit_d   = flit_sum[CNT_BITS] ? '1 : flit_sum[CNT_BITS-1:0];
      err_d    = err_sum[CNT_BITS]  ? '1 : err_sum[CNT_BITS-1:0];
      lsum_d   = lsum_sum[32]       ? '1 : lsum_sum[31:0];
      lmax_d   = (good && (latency > lmax_q)) ? latency : lmax_q;
   end

   // State, timestamp clock, LFSR and statistics registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         ts_q    <= '0;
         bad_q   <= 1'b0;
         now_q   <= '0;
         lfsr_q  <= LFSR_SEED;
         pkt_q   <= '0;
         flit_q  <= '0;
         err_q   <= '0;
         lsum_q  <= '0;
         lmax_q  <= '0;
      end else begin
         state_q <= state_d;
         ts_q    <= ts_d;
         bad_q   <= bad_d;
         now_q   <= now_q + 1'b1;
         lfsr_q  <= lfsr_d;
         pkt_q   <= pkt_d;
         flit_q  <= flit_d;
         err_q   <= err_d;
         lsum_q  <= lsum_d;
         lmax_q  <= lmax_d;
      end
   end

   assign busy       = (state_q == StBody);
   assign rx_packets = pkt_q;
   assign rx_flits   = flit_q;
   assign err_count  = err_q;
   assign lat_sum    = lsum_q;
   assign lat_max    = lmax_q;

endmodule

// File: tb/tb_traffic_sink.sv
// Directed bench for traffic_sink: vector table for framing/statistics, plus
// hand sequences for reset, mid-packet reset, stall backpressure and saturation.
module tb_traffic_sink;

   localparam logic [1:0] TB = 2'b00, TT = 2'b01, TH = 2'b10, TS = 2'b11;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        v1 = 1'b0, st1 = 1'b0;
   logic [1:0]  ty1 = 2'b00;
   logic [31:0] d1 = '0;
   logic        rdy1, busy1;
   logic [15:0] pk1, fl1, er1, lm1;
   logic [31:0] ls1;

   logic        v2 = 1'b0;
   logic [1:0]  ty2 = 2'b00;
   logic [31:0] d2 = '0;
   logic        rdy2, busy2;
   logic [3:0]  pk2, fl2, er2;
   logic [15:0] lm2;
   logic [31:0] ls2;

   logic [15:0] tnow;
   int          n_chk = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;

   // Reference timestamp: cycles since reset release.
   always @(posedge clk or negedge reset) begin
      if (!reset) tnow <= 16'd0;
      else        tnow <= tnow + 16'd1;
   end

   traffic_sink #(.MY_ADDR(5)) dut1 (
      .clk(clk), .reset(reset), .in_valid(v1), .in_type(ty1), .in_data(d1),
      .in_ready(rdy1), .stall_en(st1), .busy(busy1), .rx_packets(pk1), .rx_flits(fl1),
      .err_count(er1), .lat_sum(ls1), .lat_max(lm1)
   );

   traffic_sink #(.MY_ADDR(0), .CNT_BITS(4)) dut2 (
      .clk(clk), .reset(reset), .in_valid(v2), .in_type(ty2), .in_data(d2),
      .in_ready(rdy2), .stall_en(1'b0), .busy(busy2), .rx_packets(pk2), .rx_flits(fl2),
      .err_count(er2), .lat_sum(ls2), .lat_max(lm2)
   );

   typedef struct {
      logic       v;
      logic [1:0] ty;
      logic [3:0] dest;
      logic [15:0] lat;
      logic       busy;
      int         pk, fl, er, ls, lm;
   } vec_t;

   function automatic vec_t mk(input logic v, input logic [1:0] ty, input logic [3:0] dest,
                               input logic [15:0] lat, input logic busy, input int pk,
                               input int fl, input int er, input int ls, input int lm);
      vec_t r;
      r.v = v; r.ty = ty; r.dest = dest; r.lat = lat; r.busy = busy;
      r.pk = pk; r.fl = fl; r.er = er; r.ls = ls; r.lm = lm;
      return r;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      logic fb;
      fb = s[0] ^ s[2] ^ s[3] ^ s[5];
      return {fb, s[15:1]};
   endfunction

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   vec_t tbl[26];

   initial begin
      int          ncnt;
      int          rdy_bad;
      logic [15:0] m;

      // v ty dest lat | busy pk fl er ls lm  (ts = now - lat on head/single)
      tbl[0]  = mk(1, TS, 5, 7,   0, 1, 1,  0, 7,  7);
      tbl[1]  = mk(0, TT, 5, 0,   0, 1, 1,  0, 7,  7);
      tbl[2]  = mk(1, TH, 5, 10,  1, 1, 2,  0, 7,  7);
      tbl[3]  = mk(1, TB, 5, 0,   1, 1, 3,  0, 7,  7);
      tbl[4]  = mk(1, TB, 5, 0,   1, 1, 4,  0, 7,  7);
      tbl[5]  = mk(1, TB, 5, 0,   1, 1, 5,  0, 7,  7);
      tbl[6]  = mk(1, TT, 5, 0,   0, 2, 6,  0, 21, 14);
      tbl[7]  = mk(1, TH, 6, 0,   1, 2, 7,  0, 21, 14);
      tbl[8]  = mk(1, TT, 5, 0,   0, 2, 8,  1, 21, 14);
      tbl[9]  = mk(1, TT, 5, 0,   0, 2, 9,  2, 21, 14);
      tbl[10] = mk(1, TB, 5, 0,   0, 2, 10, 3, 21, 14);
      tbl[11] = mk(1, TH, 5, 100, 1, 2, 11, 3, 21, 14);
      tbl[12] = mk(1, TB, 5, 0,   1, 2, 12, 3, 21, 14);
      tbl[13] = mk(1, TH, 5, 3,   1, 2, 13, 4, 21, 14);
      tbl[14] = mk(1, TT, 5, 0,   0, 3, 14, 4, 25, 14);
      tbl[15] = mk(1, TH, 5, 0,   1, 3, 15, 4, 25, 14);
      tbl[16] = mk(1, TS, 5, 2,   0, 4, 16, 5, 27, 14);
      tbl[17] = mk(1, TH, 5, 0,   1, 4, 17, 5, 27, 14);
      tbl[18] = mk(1, TS, 3, 0,   0, 4, 18, 7, 27, 14);
      tbl[19] = mk(1, TS, 9, 0,   0, 4, 19, 8, 27, 14);
      tbl[20] = mk(1, TH, 5, 20,  1, 4, 20, 8, 27, 14);
      tbl[21] = mk(1, TT, 5, 0,   0, 5, 21, 8, 48, 21);
      tbl[22] = mk(0, TT, 5, 0,   0, 5, 21, 8, 48, 21);
      tbl[23] = mk(1, TH, 5, 0,   1, 5, 22, 8, 48, 21);
      tbl[24] = mk(1, TH, 2, 0,   1, 5, 23, 9, 48, 21);
      tbl[25] = mk(1, TT, 5, 0,   0, 5, 24, 10, 48, 21);

      // Reset state.
      repeat (3) @(negedge clk);
      chk("reset in_ready", rdy1, 0);
      chk("reset busy", busy1, 0);
      chk("reset rx_packets", pk1, 0);
      chk("reset rx_flits", fl1, 0);
      chk("reset err_count", er1, 0);
      chk("reset lat_sum", ls1, 0);
      chk("reset lat_max", lm1, 0);
      reset = 1'b1;
      #1;
      chk("ready after release", rdy1, 1);

      // Vector table, one flit per cycle.
      for (int i = 0; i < 26; i++) begin
         v1  = tbl[i].v;
         ty1 = tbl[i].ty;
         d1  = {12'd0, tnow - tbl[i].lat, tbl[i].dest};
         chk($sformatf("vec%0d in_ready", i), rdy1, 1);
         @(posedge clk);
         @(negedge clk);
         chk($sformatf("vec%0d busy", i), busy1, tbl[i].busy);
         chk($sformatf("vec%0d rx_packets", i), pk1, tbl[i].pk);
         chk($sformatf("vec%0d rx_flits", i), fl1, tbl[i].fl);
         chk($sformatf("vec%0d err_count", i), er1, tbl[i].er);
         chk($sformatf("vec%0d lat_sum", i), ls1, tbl[i].ls);
         chk($sformatf("vec%0d lat_max", i), lm1, tbl[i].lm);
      end

      // Reset in the middle of a packet discards it.
      v1 = 1'b1; ty1 = TH; d1 = {12'd0, tnow, 4'd5};
      @(posedge clk);
      @(negedge clk);
      v1 = 1'b0;
      chk("midreset busy before", busy1, 1);
      reset = 1'b0;
      #2;
      chk("midreset busy", busy1, 0);
      chk("midreset in_ready", rdy1, 0);
      chk("midreset rx_flits", fl1, 0);
      chk("midreset err_count", er1, 0);
      @(negedge clk);
      reset = 1'b1;
      v1 = 1'b1; ty1 = TT; d1 = {12'd0, tnow, 4'd5};
      @(posedge clk);
      @(negedge clk);
      v1 = 1'b0;
      chk("post-reset tail err", er1, 1);
      chk("post-reset tail flits", fl1, 1);
      chk("post-reset tail pkts", pk1, 0);
      chk("post-reset tail busy", busy1, 0);

      // Random backpressure against a reference LFSR.
      @(negedge clk);
      reset = 1'b0;
      st1 = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      m = 16'hACE1;
      ncnt = 0;
      rdy_bad = 0;
      v1 = 1'b1; ty1 = TS;
      for (int i = 0; i < 1000; i++) begin
         d1 = {12'd0, tnow, 4'd5};
         #1;
         if (rdy1 !== (m[1:0] != 2'b00)) rdy_bad++;
         if (m[1:0] != 2'b00) ncnt++;
         @(posedge clk);
         m = lfsr_step(m);
         @(negedge clk);
      end
      v1 = 1'b0;
      st1 = 1'b0;
      @(negedge clk);
      chk("stall ready mismatches", rdy_bad, 0);
      chk("stall rx_flits", fl1, ncnt);
      chk("stall rx_packets", pk1, ncnt);
      chk("stall err_count", er1, 0);
      chk("stall lat_max", lm1, 0);

      // Timestamp wrap and counter saturation on the narrow-counter instance.
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      v2 = 1'b1; ty2 = TS; d2 = {12'd0, 16'hFFFE, 4'd0};
      @(posedge clk);
      @(negedge clk);
      v2 = 1'b0;
      chk("wrap lat_max", lm2, 5);
      chk("wrap lat_sum", ls2, 5);
      chk("wrap rx_packets", pk2, 1);
      v2 = 1'b1;
      for (int i = 0; i < 20; i++) begin
         d2 = {12'd0, tnow - 16'd1, 4'd0};
         @(posedge clk);
         @(negedge clk);
      end
      v2 = 1'b0;
      @(negedge clk);
      chk("sat rx_packets", pk2, 15);
      chk("sat rx_flits", fl2, 15);
      chk("sat err_count", er2, 0);
      chk("sat lat_sum", ls2, 25);
      chk("sat lat_max", lm2, 5);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
